mem_access_unit: RTL

- Parametrised, multi-cycle successor to the MiniMIPS32 memory-stage access logic.
- Sits between the EXE/MEM pipeline register and the data-memory port.
- Handles byte, half, word and (when DATA_W=64) doubleword loads and stores, with signed or unsigned load extension and misalignment detection.
- Handshakes with a variable-latency memory (ack-based), stalls the pipeline while an access is outstanding, and raises a bus error on timeout.

---
 rtl/mem_access_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 69 ++++++
 rtl/mem_access_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and lane-mapping helper for the memory access unit.
package mem_access_pkg;

  // Access size encodings as carried on mem_size_i.
  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int BYTE_W = 8;

  // Byte offset within the bus word to physical lane index.
  function automatic int lane_of(input int offset, input int lanes, input bit big_endian);
    return big_endian ? (lanes - 1 - offset) : offset;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store-data placement, byte enables,
// alignment check and load-data extraction with sign/zero extension.
module mem_lane_align import mem_access_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  localparam int LANES     = DATA_W / BYTE_W,
  localparam int OFF_W     = $clog2(LANES)
) (
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              misalign_o,
  output logic [LANES-1:0]  lane_en_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  int                nbytes;
  int                off;
  logic [DATA_W-1:0] field;
  logic              sign_bit;

  // Byte of the right-aligned value that lives at a given address offset.
  // Big-endian puts the most significant byte at the lowest address.
  function automatic int value_byte(input int addr_off, input int first, input int count);
    return BIG_ENDIAN ? (first + count - 1 - addr_off) : (addr_off - first);
  endfunction

  // Decode access width and alignment; an access wider than the bus is illegal.
  always_comb begin
    nbytes     = 1 << size_i;
    off        = int'(offset_i);
    misalign_o = (nbytes > LANES) || ((off % nbytes) != 0);
  end

  // Walk the accessed byte addresses: scatter store bytes into lanes and
  // gather load bytes back into value order.
  always_comb begin
    lane_en_o = '0;
    wdata_o   = '0;
    field     = '0;
    if (!misalign_o) begin
      for (int k = 0; k < LANES; k++) begin
        if ((k >= off) && (k < off + nbytes)) begin
          lane_en_o[lane_of(k, LANES, BIG_ENDIAN)] = 1'b1;
          wdata_o[BYTE_W*lane_of(k, LANES, BIG_ENDIAN) +: BYTE_W] =
            wdata_i[BYTE_W*value_byte(k, off, nbytes) +: BYTE_W];
          field[BYTE_W*value_byte(k, off, nbytes) +: BYTE_W] =
            rdata_i[BYTE_W*lane_of(k, LANES, BIG_ENDIAN) +: BYTE_W];
        end
      end
    end
  end

  // Extend the gathered field to the full bus width; a full-width field passes through.
  always_comb begin
    sign_bit = 1'b0;
    for (int b = 0; b < LANES; b++) begin
      if (b == nbytes - 1) sign_bit = field[BYTE_W*b + BYTE_W - 1];
    end
    rdata_o = field;
    for (int b = 0; b < LANES; b++) begin
      if (b >= nbytes) rdata_o[BYTE_W*b +: BYTE_W] = {BYTE_W{sign_bit & ~unsigned_i}};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle memory-stage access unit: request register, IDLE/BUSY/DONE
// sequencer with ack timeout, and data-memory port drive.
module mem_access_unit import mem_access_pkg::*; #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter bit BIG_ENDIAN  = 1'b1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    cpu_clk_50M,
  input  logic                    cpu_rst_n,
  input  logic                    mem_req_i,
  input  logic                    mem_we_i,
  input  logic [1:0]              mem_size_i,
  input  logic                    mem_unsigned_i,
  input  logic [ADDR_W-1:0]       mem_addr_i,
  input  logic [DATA_W-1:0]       mem_wdata_i,
  output logic                    stall_o,
  output logic                    done_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    misalign_o,
  output logic                    bus_err_o,
  output logic                    dce,
  output logic [ADDR_W-1:0]       daddr,
  output logic [DATA_W/8-1:0]     we,
  output logic [DATA_W/8-1:0]     dre,
  output logic [DATA_W-1:0]       din,
  input  logic                    dm_ack_i,
  input  logic [DATA_W-1:0]       dm_rdata_i
);

  localparam int LANES = DATA_W / BYTE_W;
  localparam int OFF_W = $clog2(LANES);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              idle;
  logic              timeout_hit;
  logic              drive_bus;
  logic              acc_we;
  logic              acc_uns;
  logic [1:0]        acc_size;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  logic              al_misalign;
  logic [LANES-1:0]  al_en;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;

  assign idle        = (state_q == ST_IDLE);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // In IDLE the live request steers the lanes; afterwards the registered copy
  // does, so upstream changes during a stall cannot disturb the access.
  always_comb begin
    acc_we    = idle ? mem_we_i       : we_q;
    acc_uns   = idle ? mem_unsigned_i : uns_q;
    acc_size  = idle ? mem_size_i     : size_q;
    acc_addr  = idle ? mem_addr_i     : addr_q;
    acc_wdata = idle ? mem_wdata_i    : wdata_q;
  end

  mem_lane_align #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_align (
    .size_i     (acc_size),
    .unsigned_i (acc_uns),
    .offset_i   (acc_addr[OFF_W-1:0]),
    .wdata_i    (acc_wdata),
    .rdata_i    (rdata_q),
    .misalign_o (al_misalign),
    .lane_en_o  (al_en),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  // Sequencer next-state, request capture, completion capture and port drive.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    uns_d      = uns_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    drive_bus  = 1'b0;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    rdata_o    = '0;
    misalign_o = 1'b0;
    bus_err_o  = 1'b0;
    dce        = 1'b0;
    daddr      = '0;
    we         = '0;
    dre        = '0;
    din        = '0;

    case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          if (al_misalign) begin
            misalign_o = 1'b1;
          end else begin
            drive_bus = 1'b1;
            stall_o   = 1'b1;
            we_d      = mem_we_i;
            uns_d     = mem_unsigned_i;
            size_d    = mem_size_i;
            addr_d    = mem_addr_i;
            wdata_d   = mem_wdata_i;
            cnt_d     = '0;
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        drive_bus = 1'b1;
        stall_o   = 1'b1;
        if (dm_ack_i) begin
          rdata_d = dm_rdata_i;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        done_o    = 1'b1;
        rdata_o   = al_rdata;
        bus_err_o = err_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (drive_bus) begin
      dce   = 1'b1;
      daddr = {acc_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      we    = acc_we ? al_en : '0;
      dre   = acc_we ? '0 : al_en;
      din   = acc_we ? al_wdata : '0;
    end
  end

  // Control state and captured completion data, cleared by reset.
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
    end
  end

  // Registered address and store data; only meaningful after a capture in IDLE.
  always_ff @(posedge cpu_clk_50M) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule
